// File: rtl/ex_mdu.sv
// ex_mdu: EX-stage multiply/divide unit owning the architectural HI/LO pair.
//
// Runs multi-cycle mult/multu/div/divu from latched operands and single-cycle
// mthi/mtlo. The result of a multi-cycle op is written to HI/LO when the down-counter
// expires. Until then the hazard unit is held off through md_stall.
//
// Parameters:
//   MULT_CYCLES - busy cycles for mult/multu (>= 1)
//   DIV_CYCLES  - busy cycles for div/divu (>= 1)
//
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset
//   Req        - exception/interrupt request; drops a start in the same cycle
//   start      - md instruction valid in EX this cycle
//   md_op      - 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo
//   in_data_rs - operand A (forwarded rs)
//   in_data_rt - operand B (forwarded rt)
//   busy       - registered; high while a multi-cycle op is in flight
//   md_stall   - busy, or a multi-cycle op being accepted this cycle
//   out_HI     - architectural HI
//   out_LO     - architectural LO
//   out_mfdata - HI for mfhi, LO for mflo, otherwise 0
module ex_mdu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Req,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] in_data_rs,
   input  logic [31:0] in_data_rt,
   output logic        busy,
   output logic        md_stall,
   output logic [31:0] out_HI,
   output logic [31:0] out_LO,
   output logic [31:0] out_mfdata
);

   localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CntW      = $clog2(MaxCycles + 1);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [1:0]        op_q, op_d;      // bit1: divide, bit0: unsigned
   logic [31:0]       a_q, a_d;
   logic [31:0]       b_q, b_d;
   logic [31:0]       hi_q, hi_d;
   logic [31:0]       lo_q, lo_d;

   logic              accept;
   logic [63:0]       a_ext, b_ext, prod;
   logic              sign_div;
   logic [31:0]       a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

   // A start is only honoured from idle and without a concurrent request.
   assign accept = start & ~Req & (state_q == StIdle);

   // Product: sign- or zero-extend to 64 bits; the low 64 bits of the product are exact.
   always_comb begin
      a_ext = op_q[0] ? {32'b0, a_q} : {{32{a_q[31]}}, a_q};
      b_ext = op_q[0] ? {32'b0, b_q} : {{32{b_q[31]}}, b_q};
      prod  = a_ext * b_ext;
   end

   // Divide on magnitudes and fix signs afterwards. This keeps 0x80000000 / -1
   // well-defined (magnitude 0x80000000, negated back to itself) with no overflow trap.
   always_comb begin
      sign_div = ~op_q[0];
      a_mag    = (sign_div & a_q[31]) ? (32'd0 - a_q) : a_q;
      b_mag    = (sign_div & b_q[31]) ? (32'd0 - b_q) : b_q;
      b_safe   = (b_mag == 32'd0) ? 32'd1 : b_mag;
      q_mag    = a_mag / b_safe;
      r_mag    = a_mag % b_safe;
      quo      = (sign_div & (a_q[31] ^ b_q[31])) ? (32'd0 - q_mag) : q_mag;
      rem      = (sign_div & a_q[31]) ? (32'd0 - r_mag) : r_mag;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      hi_d    = hi_q;
      lo_d    = lo_q;

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (!md_op[2]) begin
                  op_d    = md_op[1:0];
                  a_d     = in_data_rs;
                  b_d     = in_data_rt;
                  cnt_d   = md_op[1] ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
                  state_d = StRun;
               end else if (md_op == 3'd4) begin
                  hi_d = in_data_rs;
               end else if (md_op == 3'd5) begin
                  lo_d = in_data_rs;
               end
            end
         end
         StRun: begin
            if (cnt_q == CntW'(1)) begin
               cnt_d   = '0;
               state_d = StIdle;
               if (!op_q[1]) begin
                  hi_d = prod[63:32];
                  lo_d = prod[31:0];
               end else if (b_q != 32'd0) begin
                  // Divide by zero leaves HI/LO untouched.
                  hi_d = rem;
                  lo_d = quo;
               end
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   assign busy     = (state_q == StRun);
   assign md_stall = busy | (start & ~md_op[2] & ~Req);
   assign out_HI   = hi_q;
   assign out_LO   = lo_q;

   always_comb begin
      out_mfdata = 32'd0;
      case (md_op)
         3'd6:    out_mfdata = hi_q;
         3'd7:    out_mfdata = lo_q;
         default: out_mfdata = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: self-checking bench for ex_mdu.
// A directed table with hand-derived results, random operations checked against an
// arithmetic model, and hand-written sequences for Req, back-to-back starts and reset.
module tb_ex_mdu;

   localparam int unsigned MC = 5;
   localparam int unsigned DC = 10;

   logic        clk;
   logic        rst_n;
   logic        req;
   logic        start;
   logic [2:0]  md_op;
   logic [31:0] rs;
   logic [31:0] rt;
   logic        busy;
   logic        md_stall;
   logic [31:0] out_hi;
   logic [31:0] out_lo;
   logic [31:0] out_mfdata;

   int vectors;
   int miscompares;

   logic [31:0] m_hi;
   logic [31:0] m_lo;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_hi;
      logic [31:0] exp_lo;
   } vec_t;

   vec_t tbl[9];

   ex_mdu #(
      .MULT_CYCLES (MC),
      .DIV_CYCLES  (DC)
   ) u_dut (
      .clk        (clk),
      .reset      (rst_n),
      .Req        (req),
      .start      (start),
      .md_op      (md_op),
      .in_data_rs (rs),
      .in_data_rt (rt),
      .busy       (busy),
      .md_stall   (md_stall),
      .out_HI     (out_hi),
      .out_LO     (out_lo),
      .out_mfdata (out_mfdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
      end
   endtask

   function automatic int lat_of(input logic [2:0] op);
      if (op < 3'd2)      return int'(MC);
      else if (op < 3'd4) return int'(DC);
      else                return 0;
   endfunction

   // Reference model: architectural effect of one accepted operation.
   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb, sq, sr;
      logic [63:0] p;
      case (op)
         3'd0: begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p  = 64'(sa * sb);
            m_hi = p[63:32];
            m_lo = p[31:0];
         end
         3'd1: begin
            p  = {32'd0, a} * {32'd0, b};
            m_hi = p[63:32];
            m_lo = p[31:0];
         end
         3'd2: if (b != 32'd0) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            sq = sa / sb;
            sr = sa % sb;
            m_lo = sq[31:0];
            m_hi = sr[31:0];
         end
         3'd3: if (b != 32'd0) begin
            m_lo = a / b;
            m_hi = a % b;
         end
         3'd4: m_hi = a;
         3'd5: m_lo = a;
         default: ;
      endcase
   endtask

   task automatic check_mf();
      md_op = 3'd6;
      #1 check("mfhi", out_mfdata, m_hi);
      md_op = 3'd7;
      #1 check("mflo", out_mfdata, m_lo);
      md_op = 3'd0;
      #1 check("mfdata_other", out_mfdata, 32'd0);
   endtask

   // Issue one op with Req=0, scramble inputs while it runs, then check latency and HI/LO.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      int n;
      @(negedge clk);
      start = 1'b1;
      md_op = op;
      rs    = a;
      rt    = b;
      req   = 1'b0;
      #1 check("md_stall_issue", {31'b0, md_stall}, {31'b0, (op < 3'd4)});
      @(negedge clk);
      start = 1'b0;
      md_op = 3'd0;
      rs    = $urandom;
      rt    = $urandom;
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      model(op, a, b);
      check("latency", 32'(n), 32'(lat_of(op)));
      check("hi", out_hi, m_hi);
      check("lo", out_lo, m_lo);
      check_mf();
   endtask

   initial begin
      int          n;
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      int          sel;

      vectors     = 0;
      miscompares = 0;
      m_hi        = 32'd0;
      m_lo        = 32'd0;

      tbl[0] = '{3'd0, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
      tbl[1] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      tbl[2] = '{3'd2, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      tbl[3] = '{3'd3, 32'h0000_0007, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      tbl[4] = '{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
      tbl[5] = '{3'd3, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E};
      tbl[6] = '{3'd2, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
      tbl[7] = '{3'd4, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFD};
      tbl[8] = '{3'd5, 32'hCAFE_BABE, 32'h0000_0000, 32'h1234_5678, 32'hCAFE_BABE};

      rst_n = 1'b0;
      req   = 1'b0;
      start = 1'b0;
      md_op = 3'd0;
      rs    = 32'd0;
      rt    = 32'd0;
      repeat (2) @(negedge clk);
      check("reset_busy", {31'b0, busy}, 32'd0);
      check("reset_stall", {31'b0, md_stall}, 32'd0);
      check("reset_hi", out_hi, 32'd0);
      check("reset_lo", out_lo, 32'd0);
      rst_n = 1'b1;

      // Directed table.
      foreach (tbl[i]) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b);
         check("tbl_hi", out_hi, tbl[i].exp_hi);
         check("tbl_lo", out_lo, tbl[i].exp_lo);
      end

      // Req cancels a same-cycle start: mthi, then mult.
      @(negedge clk);
      start = 1'b1;
      md_op = 3'd4;
      rs    = 32'h0BAD_F00D;
      req   = 1'b1;
      #1 check("req_mthi_stall", {31'b0, md_stall}, 32'd0);
      @(negedge clk);
      check("req_mthi_hi", out_hi, m_hi);
      check("req_mthi_busy", {31'b0, busy}, 32'd0);
      md_op = 3'd0;
      rs    = 32'd9;
      rt    = 32'd9;
      #1 check("req_mult_stall", {31'b0, md_stall}, 32'd0);
      @(negedge clk);
      start = 1'b0;
      req   = 1'b0;
      check("req_mult_busy", {31'b0, busy}, 32'd0);
      check("req_mult_lo", out_lo, m_lo);

      // Mult with Req raised mid-run and a second start while busy.
      @(negedge clk);
      start = 1'b1;
      md_op = 3'd0;
      rs    = 32'h0001_0003;
      rt    = 32'hFFFF_FFF0;
      @(negedge clk);
      n = 0;
      while (busy && n < 100) begin
         n++;
         start = (n == 1);
         md_op = 3'd2;
         rs    = 32'd100;
         rt    = 32'd3;
         req   = (n == 2);
         #1 check("busy_stall", {31'b0, md_stall}, 32'd1);
         @(negedge clk);
      end
      start = 1'b0;
      req   = 1'b0;
      model(3'd0, 32'h0001_0003, 32'hFFFF_FFF0);
      check("req_run_latency", 32'(n), 32'(MC));
      check("req_run_hi", out_hi, m_hi);
      check("req_run_lo", out_lo, m_lo);
      @(negedge clk);
      check("second_start_ignored", {31'b0, busy}, 32'd0);

      // Random operations against the model.
      for (int k = 0; k < 40; k++) begin
         op  = 3'($urandom_range(0, 5));
         a   = $urandom;
         b   = $urandom;
         sel = $urandom_range(0, 5);
         if (sel == 0) b = 32'd0;
         else if (sel == 1) begin
            a = 32'h8000_0000;
            b = 32'hFFFF_FFFF;
         end else if (sel == 2) b = 32'($urandom_range(1, 9));
         run_op(op, a, b);
      end

      // Reset in the middle of a divide.
      run_op(3'd4, 32'hA5A5_5A5A, 32'd0);
      run_op(3'd5, 32'h5A5A_A5A5, 32'd0);
      @(negedge clk);
      start = 1'b1;
      md_op = 3'd2;
      rs    = 32'd1000;
      rt    = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_reset_busy", {31'b0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("abort_busy", {31'b0, busy}, 32'd0);
      check("abort_hi", out_hi, 32'd0);
      check("abort_lo", out_lo, 32'd0);
      m_hi = 32'd0;
      m_lo = 32'd0;
      @(negedge clk);
      rst_n = 1'b1;
      md_op = 3'd7;
      #1 check("post_reset_mflo", out_mfdata, 32'd0);
      md_op = 3'd0;
      repeat (DC + 2) @(negedge clk);
      check("post_reset_idle", {31'b0, busy}, 32'd0);
      check("post_reset_hi", out_hi, 32'd0);
      check("post_reset_lo", out_lo, 32'd0);
      run_op(3'd1, 32'd12345, 32'd6789);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
